// File: rtl/imem_loader.sv
// Instruction-memory loader: takes a word stream and writes it into IMEM at
// consecutive addresses, holding the CPU off while a load is in progress.
//
// state  | meaning
// IDLE   | waiting for start; range check and zero-count handled here
// LOAD   | accepting words, one IMEM write registered per handshake
// FINISH | last write presented; done and cpu_hold release follow
module imem_loader #(
  parameter int DEPTH     = 1024,
  parameter bit BOOT_HOLD = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [31:0] word_cnt,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        im_write,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  localparam logic [32:0] DEPTH_EXT = 33'(DEPTH);

  logic [1:0]  state;
  logic [31:0] ptr;
  logic [31:0] cnt;
  logic [32:0] end_addr;
  logic        range_bad;
  logic        handshake;

  // 33-bit sum so a huge base/count pair cannot wrap past the check
  assign end_addr  = {1'b0, base_addr} + {1'b0, word_cnt};
  assign range_bad = end_addr > DEPTH_EXT;
  assign in_ready  = (state == LOAD);
  assign busy      = (state != IDLE);
  assign handshake = in_ready & in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      cnt      <= '0;
      im_write <= 1'b0;
      im_addr  <= '0;
      im_wdata <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      cpu_hold <= BOOT_HOLD;
    end else begin
      im_write <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ptr <= base_addr;
            cnt <= word_cnt;
            if (range_bad) begin
              err <= 1'b1;
            end else begin
              err <= 1'b0;
              if (word_cnt == 32'd0) begin
                done     <= 1'b1;
                cpu_hold <= 1'b0;
              end else begin
                state    <= LOAD;
                cpu_hold <= 1'b1;
              end
            end
          end
        end
        LOAD: begin
          if (handshake) begin
            im_write <= 1'b1;
            im_addr  <= ptr;
            im_wdata <= in_data;
            ptr      <= ptr + 32'd1;
            cnt      <= cnt - 32'd1;
            if (cnt == 32'd1) state <= FINISH;
          end
        end
        FINISH: begin
          state    <= IDLE;
          done     <= 1'b1;
          cpu_hold <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and random loads compared
// against an address->data memory model and expected handshake timing.
module tb_imem_loader;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [31:0] word_cnt = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready, im_write, cpu_hold, busy, done, err;
  logic [31:0] im_addr, im_wdata;

  imem_loader #(.DEPTH(DEPTH), .BOOT_HOLD(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .word_cnt(word_cnt), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .im_write(im_write), .im_addr(im_addr),
    .im_wdata(im_wdata), .cpu_hold(cpu_hold), .busy(busy), .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] ref_mem [int];
  logic [31:0] dut_mem [int];
  int n_ref_wr = 0, n_dut_wr = 0;
  int n_ref_done = 0, n_dut_done = 0;
  logic exp_hold = 1'b1;
  logic exp_err = 1'b0;
  logic [31:0] prev_addr = '0, prev_data = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Passive monitor: records every write and checks address/data hold between writes
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_addr = '0;
      prev_data = '0;
    end else begin
      if (im_write) begin
        dut_mem[int'(im_addr)] = im_wdata;
        n_dut_wr++;
      end else begin
        chk("hold_addr", im_addr, prev_addr);
        chk("hold_data", im_wdata, prev_data);
      end
      if (done) n_dut_done++;
      prev_addr = im_addr;
      prev_data = im_wdata;
    end
  end

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wr", im_write, 0);
    chk("rst_addr", im_addr, 0);
    chk("rst_data", im_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rdy", in_ready, 0);
    chk("rst_hold", cpu_hold, 1);
    start = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    exp_hold = 1'b1;
    exp_err = 1'b0;
    @(negedge clk);
  endtask

  // gap_mode: 0 back-to-back, 1 random gaps, 2 three-cycle gap after 2nd word.
  // rst_after: reset right after that many writes have appeared (-1 = never).
  task automatic run_load(input logic [31:0] base, input logic [31:0] cnt, input int gap_mode,
                          input bit fixed_data, input bit busy_start, input int rst_after);
    longint sum;
    bit ok;
    logic [31:0] w;
    int g;
    sum = longint'(base) + longint'(cnt);
    ok = (sum <= longint'(DEPTH));
    start = 1'b1;
    base_addr = base;
    word_cnt = cnt;
    in_valid = 1'($urandom_range(0, 1));
    in_data = $urandom;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b0;
    base_addr = $urandom;
    word_cnt = $urandom;
    if (!ok) begin
      exp_err = 1'b1;
      chk("rej_err", err, 1);
      chk("rej_busy", busy, 0);
      chk("rej_rdy", in_ready, 0);
      chk("rej_hold", cpu_hold, exp_hold);
      chk("rej_done", done, 0);
      repeat (3) begin
        in_valid = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("rej_wr", im_write, 0);
        chk("rej_rdy2", in_ready, 0);
        chk("rej_sticky", err, 1);
      end
      in_valid = 1'b0;
      return;
    end
    exp_err = 1'b0;
    if (cnt == 0) begin
      n_ref_done++;
      exp_hold = 1'b0;
      chk("zero_done", done, 1);
      chk("zero_busy", busy, 0);
      chk("zero_err", err, 0);
      chk("zero_hold", cpu_hold, exp_hold);
      @(negedge clk);
      chk("zero_done_end", done, 0);
      chk("zero_wr", im_write, 0);
      chk("zero_busy2", busy, 0);
      return;
    end
    exp_hold = 1'b1;
    chk("ld_busy", busy, 1);
    chk("ld_rdy", in_ready, 1);
    chk("ld_hold", cpu_hold, 1);
    chk("ld_err", err, 0);
    chk("ld_done", done, 0);
    for (int i = 0; i < int'(cnt); i++) begin
      g = (gap_mode == 1) ? int'($urandom_range(0, 2)) : ((gap_mode == 2 && i == 2) ? 3 : 0);
      for (int k = 0; k < g; k++) begin
        in_valid = 1'b0;
        in_data = $urandom;
        @(negedge clk);
        chk("gap_wr", im_write, 0);
        chk("gap_busy", busy, 1);
        chk("gap_rdy", in_ready, 1);
      end
      w = fixed_data ? (32'hA0 + 32'(i)) : $urandom;
      in_valid = 1'b1;
      in_data = w;
      if (busy_start && i == 1) begin
        start = 1'b1;
        base_addr = base + 32'd100;
        word_cnt = 32'd2;
      end
      @(negedge clk);
      start = 1'b0;
      chk("wr_en", im_write, 1);
      chk("wr_addr", im_addr, base + 32'(i));
      chk("wr_data", im_wdata, w);
      ref_mem[int'(base) + i] = w;
      n_ref_wr++;
      if (busy_start) chk("busy_start_err", err, 0);
      if (rst_after == i + 1) begin
        do_reset();
        return;
      end
    end
    chk("fin_busy", busy, 1);
    chk("fin_rdy", in_ready, 0);
    chk("fin_done", done, 0);
    in_valid = 1'($urandom_range(0, 1));
    in_data = $urandom;
    @(negedge clk);
    n_ref_done++;
    exp_hold = 1'b0;
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_hold", cpu_hold, 0);
    chk("end_wr", im_write, 0);
    chk("end_rdy", in_ready, 0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("end_done_pulse", done, 0);
    chk("idle_hold", cpu_hold, 0);
  endtask

  initial begin
    logic [31:0] rb, rc;
    repeat (2) @(negedge clk);
    chk("por_busy", busy, 0);
    chk("por_hold", cpu_hold, 1);
    chk("por_wr", im_write, 0);
    chk("por_err", err, 0);
    #2 rst_n = 1'b1;
    repeat (3) begin
      in_valid = 1'b1;
      in_data = $urandom;
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_rdy", in_ready, 0);
    end
    in_valid = 1'b0;

    run_load(32'd1021, 32'd4, 0, 1'b0, 1'b0, -1);
    run_load(32'd1020, 32'd4, 0, 1'b0, 1'b0, -1);
    chk("last_addr", prev_addr, 32'd1023);
    run_load(32'h10, 32'd4, 0, 1'b1, 1'b0, -1);
    run_load(32'h10, 32'd4, 2, 1'b1, 1'b0, -1);
    for (int a = 0; a < 4; a++) chk("stall_mem", ref_mem[16 + a], 32'hA0 + 32'(a));
    run_load(32'd1021, 32'd4, 0, 1'b0, 1'b0, -1);
    run_load(32'hFFFF_FFFF, 32'd2, 0, 1'b0, 1'b0, -1);
    run_load(32'd5, 32'd0, 0, 1'b0, 1'b0, -1);
    run_load(32'h40, 32'd8, 0, 1'b0, 1'b0, 2);
    run_load(32'h80, 32'd5, 1, 1'b0, 1'b0, -1);
    run_load(32'h200, 32'd6, 0, 1'b0, 1'b1, -1);

    for (int n = 0; n < 25; n++) begin
      rb = $urandom_range(0, DEPTH - 1);
      rc = $urandom_range(0, 3) == 0 ? $urandom_range(0, 40) : $urandom_range(0, 10);
      if ($urandom_range(0, 5) == 0) rc = 32'(DEPTH) - rb + 32'd1;
      run_load(rb, rc, 1, 1'b0, 1'($urandom_range(0, 3) == 0), -1);
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("rnd_idle_busy", busy, 0);
        chk("rnd_idle_err", err, exp_err);
        chk("rnd_idle_hold", cpu_hold, exp_hold);
      end
      in_valid = 1'b0;
    end

    repeat (2) @(negedge clk);
    chk("wr_count", n_dut_wr, n_ref_wr);
    chk("done_count", n_dut_done, n_ref_done);
    chk("mem_size", dut_mem.size(), ref_mem.size());
    foreach (ref_mem[a]) begin
      if (dut_mem.exists(a)) chk("mem_word", dut_mem[a], ref_mem[a]);
      else chk("mem_missing", 32'hFFFF_FFFF, 32'(a));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
